// File: rtl/result_output_stage.sv
// Purpose: two-entry output FIFO for FP results, with optional NaN canonicalisation and sticky exception flags.
// Latency: 1 cycle. An entry pushed on edge N is at the output after edge N.
// Backpressure: in_ready comes from registered occupancy only. It deasserts when both entries are full.
//
// Ports:
//   clk, reset                    clock, asynchronous active-high reset
//   in_valid/in_ready             upstream handshake for in_result/in_flags/in_tag
//   out_valid/out_ready           downstream handshake for out_result/out_flags/out_tag (head entry)
//   sticky_flags, flags_clear     OR-accumulated flags of every accepted entry, synchronous clear
module result_output_stage #(
    parameter int CANONICAL_NAN = 1,
    parameter int TAG_WIDTH     = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_result,
    input  logic [4:0]           in_flags,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_result,
    output logic [4:0]           out_flags,
    output logic [TAG_WIDTH-1:0] out_tag,
    output logic [4:0]           sticky_flags,
    input  logic                 flags_clear
);

    localparam logic [31:0] QNAN = 32'h7FC0_0000;

    logic [31:0]          result_q [0:1];
    logic [4:0]           flags_q  [0:1];
    logic [TAG_WIDTH-1:0] tag_q    [0:1];
    logic                 wr_ptr;
    logic                 rd_ptr;
    logic [1:0]           count;
    // Holds in_ready low while reset is asserted. It rises on the first edge after reset is released.
    logic                 ready_en;

    logic        push;
    logic        pop;
    logic        in_is_nan;
    logic [31:0] wr_result;

    assign in_ready  = ready_en & ~count[1];
    assign out_valid = (count != 2'd0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    // Only NaNs are rewritten. Infinities, zeros and denormals are stored unchanged.
    assign in_is_nan = (in_result[30:23] == 8'hFF) && (in_result[22:0] != 23'd0);
    assign wr_result = ((CANONICAL_NAN != 0) && in_is_nan) ? QNAN : in_result;

    assign out_result = result_q[rd_ptr];
    assign out_flags  = flags_q[rd_ptr];
    assign out_tag    = tag_q[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            result_q[0]  <= '0;
            result_q[1]  <= '0;
            flags_q[0]   <= '0;
            flags_q[1]   <= '0;
            tag_q[0]     <= '0;
            tag_q[1]     <= '0;
            wr_ptr       <= 1'b0;
            rd_ptr       <= 1'b0;
            count        <= 2'd0;
            ready_en     <= 1'b0;
            sticky_flags <= 5'd0;
        end else begin
            ready_en <= 1'b1;

            if (push) begin
                result_q[wr_ptr] <= wr_result;
                flags_q[wr_ptr]  <= in_flags;
                tag_q[wr_ptr]    <= in_tag;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end

            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase

            // Clear takes priority. A push in the same cycle then seeds the fresh accumulation.
            if (flags_clear) begin
                sticky_flags <= push ? in_flags : 5'd0;
            end else if (push) begin
                sticky_flags <= sticky_flags | in_flags;
            end
        end
    end

endmodule

// File: tb/tb_result_output_stage.sv
module tb_result_output_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_result;
    logic [4:0]  in_flags;
    logic [3:0]  in_tag;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_flags;
    logic [3:0]  out_tag;
    logic [4:0]  sticky_flags;
    logic        flags_clear;

    // Second instance with NaN canonicalisation disabled. It shares all inputs.
    logic        n0_in_ready;
    logic        n0_out_valid;
    logic [31:0] n0_out_result;
    logic [4:0]  n0_out_flags;
    logic [3:0]  n0_out_tag;
    logic [4:0]  n0_sticky_flags;

    always #5 clk = ~clk;

    result_output_stage #(.CANONICAL_NAN(1), .TAG_WIDTH(4)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags), .out_tag(out_tag),
        .sticky_flags(sticky_flags), .flags_clear(flags_clear)
    );

    result_output_stage #(.CANONICAL_NAN(0), .TAG_WIDTH(4)) dut_n0 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(n0_in_ready),
        .in_result(in_result), .in_flags(in_flags), .in_tag(in_tag),
        .out_valid(n0_out_valid), .out_ready(out_ready),
        .out_result(n0_out_result), .out_flags(n0_out_flags), .out_tag(n0_out_tag),
        .sticky_flags(n0_sticky_flags), .flags_clear(flags_clear)
    );

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        logic [3:0]  tag;
    } entry_t;

    // Reference model: queue of accepted raw entries, ready flag and sticky flags.
    entry_t     mq[$];
    bit         m_rdy;
    logic [4:0] m_sticky;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    function automatic logic [31:0] canon(input logic [31:0] r);
        if (r[30:23] == 8'hFF && r[22:0] != 0) return 32'h7FC0_0000;
        return r;
    endfunction

    function automatic bit m_in_ready();
        return m_rdy && (mq.size() < 2);
    endfunction

    // Advances one clock. The model is updated from the inputs and model state present before the edge.
    task automatic tick();
        bit     push;
        bit     pop;
        entry_t e;
        push  = in_valid && m_in_ready();
        pop   = (mq.size() != 0) && out_ready;
        e.res = in_result;
        e.fl  = in_flags;
        e.tag = in_tag;
        @(posedge clk);
        #1;
        if (reset) begin
            mq.delete();
            m_rdy    = 0;
            m_sticky = 5'd0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) mq.push_back(e);
            if (flags_clear) m_sticky = push ? e.fl : 5'd0;
            else if (push)   m_sticky = m_sticky | e.fl;
            m_rdy = 1;
        end
    endtask

    task automatic idle_inputs();
        in_valid    = 0;
        in_result   = 32'h0;
        in_flags    = 5'h0;
        in_tag      = 4'h0;
        out_ready   = 0;
        flags_clear = 0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1;
        mq.delete();
        m_rdy    = 0;
        m_sticky = 0;
        #22;
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid got %b want 0", out_valid); else pass_cnt++;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_in_ready got %b want 0", in_ready); else pass_cnt++;
        chk_cnt++; if (out_result !== 32'h0) $display("FAIL rst_out_result got %h want 0", out_result); else pass_cnt++;
        chk_cnt++; if (out_flags !== 5'h0 || out_tag !== 4'h0) $display("FAIL rst_flags_tag got %h/%h want 0/0", out_flags, out_tag); else pass_cnt++;
        chk_cnt++; if (sticky_flags !== 5'h0) $display("FAIL rst_sticky got %b want 0", sticky_flags); else pass_cnt++;
        reset = 0;
        #1;
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL rst_release_ready got %b want 0", in_ready); else pass_cnt++;
        tick();
        chk_cnt++; if (in_ready !== 1'b1) $display("FAIL rst_first_edge_ready got %b want 1", in_ready); else pass_cnt++;
    endtask

    task automatic test_single();
        out_ready = 1;
        in_valid  = 1;
        in_result = 32'h3F80_0000;
        in_flags  = 5'b00001;
        in_tag    = 4'd3;
        tick();
        in_valid = 0;
        chk_cnt++; if (out_valid !== 1'b1) $display("FAIL single_valid got %b want 1", out_valid); else pass_cnt++;
        chk_cnt++; if (out_result !== 32'h3F80_0000) $display("FAIL single_result got %h want 3f800000", out_result); else pass_cnt++;
        chk_cnt++; if (out_tag !== 4'd3) $display("FAIL single_tag got %0d want 3", out_tag); else pass_cnt++;
        chk_cnt++; if (sticky_flags !== 5'b00001) $display("FAIL single_sticky got %b want 00001", sticky_flags); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL single_drain got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_backpressure();
        out_ready = 0;
        in_valid  = 1;
        in_flags  = 5'b0;
        in_result = 32'h4000_0000;
        in_tag    = 4'd1;
        tick();
        in_result = 32'h4040_0000;
        in_tag    = 4'd2;
        tick();
        chk_cnt++; if (in_ready !== 1'b0) $display("FAIL bp_full_ready got %b want 0", in_ready); else pass_cnt++;
        in_result = 32'h4080_0000;
        in_tag    = 4'd9;
        tick();
        chk_cnt++; if (out_tag !== 4'd1 || out_result !== 32'h4000_0000) $display("FAIL bp_hold got tag %0d res %h want 1 40000000", out_tag, out_result); else pass_cnt++;
        in_valid  = 0;
        out_ready = 1;
        tick();
        chk_cnt++; if (out_valid !== 1'b1 || out_tag !== 4'd2) $display("FAIL bp_second got v%b tag %0d want v1 tag 2", out_valid, out_tag); else pass_cnt++;
        tick();
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL bp_empty got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_streaming();
        out_ready = 1;
        in_valid  = 1;
        in_flags  = 5'b0;
        in_tag    = 4'd0;
        in_result = 32'h3F00_0000;
        tick();
        for (int i = 1; i <= 8; i++) begin
            chk_cnt++;
            if (out_valid !== 1'b1 || in_ready !== 1'b1 || out_tag !== 4'(i - 1))
                $display("FAIL stream_%0d got v%b r%b tag %0d want v1 r1 tag %0d", i, out_valid, in_ready, out_tag, i - 1);
            else pass_cnt++;
            in_valid  = (i < 8);
            in_tag    = 4'(i);
            in_result = 32'h3F00_0000 + i;
            tick();
        end
        chk_cnt++; if (out_valid !== 1'b0) $display("FAIL stream_empty got %b want 0", out_valid); else pass_cnt++;
    endtask

    task automatic test_nan();
        logic [31:0] vals [4];
        logic [31:0] want;
        vals[0] = 32'hFFC1_2345;
        vals[1] = 32'h7F80_0000;
        vals[2] = 32'h0000_0001;
        vals[3] = 32'h8000_0000;
        out_ready = 1;
        for (int i = 0; i < 4; i++) begin
            in_valid  = 1;
            in_result = vals[i];
            in_flags  = 5'b10000;
            in_tag    = 4'(4 + i);
            tick();
            in_valid = 0;
            want = (i == 0) ? 32'h7FC0_0000 : vals[i];
            chk_cnt++; if (out_result !== want || out_flags !== 5'b10000 || out_tag !== 4'(4 + i))
                $display("FAIL nan_canon_%0d got %h fl %b tag %0d want %h fl 10000 tag %0d", i, out_result, out_flags, out_tag, want, 4 + i);
            else pass_cnt++;
            chk_cnt++; if (n0_out_result !== vals[i]) $display("FAIL nan_pass_%0d got %h want %h", i, n0_out_result, vals[i]); else pass_cnt++;
            tick();
        end
    endtask

    task automatic test_sticky();
        out_ready   = 1;
        in_valid    = 1;
        flags_clear = 1;
        in_flags    = 5'b10000;
        tick();
        chk_cnt++; if (sticky_flags !== 5'b10000) $display("FAIL sticky_seed got %b want 10000", sticky_flags); else pass_cnt++;
        in_flags = 5'b00100;
        tick();
        chk_cnt++; if (sticky_flags !== 5'b00100) $display("FAIL sticky_clear_push got %b want 00100", sticky_flags); else pass_cnt++;
        flags_clear = 0;
        in_flags    = 5'b00010;
        tick();
        chk_cnt++; if (sticky_flags !== 5'b00110) $display("FAIL sticky_or got %b want 00110", sticky_flags); else pass_cnt++;
        in_valid    = 0;
        flags_clear = 1;
        tick();
        chk_cnt++; if (sticky_flags !== 5'b00000) $display("FAIL sticky_clear got %b want 00000", sticky_flags); else pass_cnt++;
        flags_clear = 0;
        tick();
        tick();
    endtask

    task automatic test_random();
        int errs;
        errs = 0;
        for (int c = 0; c < 400; c++) begin
            in_valid    = ($urandom_range(0, 3) != 0);
            out_ready   = ($urandom_range(0, 2) != 0);
            flags_clear = ($urandom_range(0, 15) == 0);
            in_flags    = 5'($urandom);
            in_tag      = 4'($urandom);
            case ($urandom_range(0, 3))
                0:       in_result = {1'($urandom), 8'hFF, 23'($urandom) | 23'd1};
                1:       in_result = {1'($urandom), 8'hFF, 23'd0};
                default: in_result = $urandom;
            endcase
            tick();
            chk_cnt++;
            if (out_valid !== (mq.size() != 0) || in_ready !== m_in_ready() || sticky_flags !== m_sticky
                || (mq.size() != 0 && (out_result !== canon(mq[0].res) || out_flags !== mq[0].fl
                    || out_tag !== mq[0].tag || n0_out_result !== mq[0].res))) begin
                if (errs < 10)
                    $display("FAIL random_%0d got v%b r%b st%b res %h/%h tag %0d want v%b r%b st%b", c, out_valid, in_ready,
                             sticky_flags, out_result, n0_out_result, out_tag, mq.size() != 0, m_in_ready(), m_sticky);
                errs++;
            end else pass_cnt++;
        end
        in_valid    = 0;
        flags_clear = 0;
    endtask

    task automatic test_reset_mid();
        out_ready = 0;
        in_valid  = 1;
        in_flags  = 5'b00011;
        in_tag    = 4'd5;
        while (m_in_ready()) tick();
        in_valid = 0;
        chk_cnt++; if (out_valid !== 1'b1 || in_ready !== 1'b0) $display("FAIL midrst_full got v%b r%b want v1 r0", out_valid, in_ready); else pass_cnt++;
        #2;
        reset = 1;
        #1;
        chk_cnt++; if (out_valid !== 1'b0 || in_ready !== 1'b0) $display("FAIL midrst_async got v%b r%b want v0 r0", out_valid, in_ready); else pass_cnt++;
        chk_cnt++; if (sticky_flags !== 5'd0) $display("FAIL midrst_sticky got %b want 0", sticky_flags); else pass_cnt++;
        mq.delete();
        m_rdy    = 0;
        m_sticky = 0;
        #1;
        reset = 0;
        tick();
        chk_cnt++; if (in_ready !== 1'b1 || out_valid !== 1'b0) $display("FAIL midrst_release got r%b v%b want r1 v0", in_ready, out_valid); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_nan();
        test_sticky();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule

// File: doc/result_output_stage.md
RESULT_OUTPUT_STAGE -- requirements
Module: result_output_stage

Interface
REQ-001 Parameter CANONICAL_NAN, default 1, meaning: 1 replaces any NaN result with 32'h7FC0_0000 at enqueue; 0 passes the NaN unchanged.
REQ-002 Parameter TAG_WIDTH, default 4, meaning: width of the opaque operation tag carried alongside each result.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  upstream result/flags/tag are valid this cycle.
REQ-006 in_ready  output  1  stage can accept an entry this cycle.
REQ-007 in_result  input  32  packed IEEE-754 single result from the result-selection stage.
REQ-008 in_flags  input  5  exception flags {invalid, div_by_zero, overflow, underflow, inexact}, MSB first.
REQ-009 in_tag  input  TAG_WIDTH  operation tag.
REQ-010 out_valid  output  1  out_result/out_flags/out_tag hold a valid entry.
REQ-011 out_ready  input  1  downstream consumes the entry this cycle.
REQ-012 out_result  output  32  head-entry result.
REQ-013 out_flags  output  5  head-entry flags.
REQ-014 out_tag  output  TAG_WIDTH  head-entry tag.
REQ-015 sticky_flags  output  5  accumulated flags since the last clear.
REQ-016 flags_clear  input  1  clears sticky_flags synchronously.

Function
REQ-017 The block SHALL be a 2-entry FIFO (entries 0/1); push = in_valid & in_ready; pop = out_valid & out_ready.
REQ-018 in_ready SHALL equal (count < 2) and SHALL be driven from registered state only, with no combinational path from out_ready.
REQ-019 out_valid SHALL equal (count != 0); out_result/out_flags/out_tag SHALL come directly from the head register.
REQ-020 Latency SHALL be exactly 1 cycle: an entry pushed at edge N is visible at the output after edge N.
REQ-021 Sustained throughput SHALL be 1 entry per cycle while out_ready stays high.
REQ-022 Count transitions: push only -> +1; pop only -> -1; push and pop with count=1 -> count stays 1, new entry becomes head after the pop; push with count=2 cannot occur.
REQ-023 Entry order SHALL be strictly FIFO; read and write pointers SHALL be 1 bit each and wrap 1 -> 0.
REQ-024 With CANONICAL_NAN=1, an input with exponent 8'hFF and nonzero fraction SHALL be stored as 32'h7FC0_0000, with flags and tag unchanged.
REQ-025 Infinities, zeros and denormals SHALL be stored bit-exact.
REQ-026 On every push, sticky_flags SHALL become sticky_flags | in_flags.
REQ-027 When flags_clear and push occur in the same cycle, sticky_flags SHALL become in_flags (clear first, then OR).
REQ-028 When flags_clear occurs without a push, sticky_flags SHALL become 5'b0.
REQ-029 Inputs SHALL be ignored when in_ready=0; out_valid=0 with out_ready=1 SHALL change no state.
REQ-030 While out_valid=1 and out_ready=0, the output bus SHALL hold stable.

Reset
REQ-031 While reset is asserted: count=0, pointers=0, out_valid=0, in_ready=0, out_result=32'h0, out_flags=5'h0, out_tag=0, sticky_flags=5'h0.
REQ-032 in_ready SHALL rise on the first clk edge after reset deasserts.
REQ-033 Reset asserted mid-transfer SHALL discard all stored entries immediately, asynchronously to clk.

Verification
REQ-034 Single push of 32'h3F80_0000, flags 5'b00001, tag 3, out_ready=1 -> next cycle out_valid=1, out_result=32'h3F80_0000, out_tag=3, sticky_flags=5'b00001; the following cycle out_valid=0.
REQ-035 out_ready=0, push tags 1 and 2 -> in_ready=0 after the second push, a third push is ignored; then out_ready=1 -> out_tag 1 then 2, then out_valid=0.
REQ-036 Streaming 8 pushes with out_ready=1 at count=1 -> count stays 1; tags exit in order 0..7 at 1 per cycle.
REQ-037 CANONICAL_NAN=1, push 32'hFFC1_2345 -> out_result=32'h7FC0_0000; push 32'h7F80_0000 -> output unchanged (infinity); CANONICAL_NAN=0 -> 32'hFFC1_2345 passes through.
REQ-038 sticky_flags=5'b10000, then flags_clear together with a push of flags 5'b00100 -> sticky_flags=5'b00100; flags_clear alone -> 5'b00000.
REQ-039 count=2, assert reset between edges -> out_valid and in_ready fall immediately; after release, in_ready=1 and out_valid=0.
